bus_cycle_sequencer: RTL and testbench
======================================

// Module: bus_cycle_sequencer
// PURPOSE
//  Clocked DTACK/BERR sequencer for the 68000 bus. Per-region wait states: the address decoder supplies REGION_IN.
//  Also provides single-step pausing and an optional unmapped-access bus-error timeout.
//  Sits between the address decoder (chip selects) and the CPU DTACK/BERR pins.
// PARAMETERS
//  PROM_WAIT  2    wait cycles added for PROM (flash) accesses
//  SRAM_WAIT  0    wait cycles added for SRAM accesses
//  IO_WAIT    1    wait cycles added for I/O port accesses
//  TIMEOUT    64   cycles before BERR on an unmapped access (BUS_TIMEOUT_EN only)
//  CNT_W      8    counter width; must hold max(all *_WAIT, TIMEOUT)
// PORTS
//  CPUCLK_IN     in   1  CPU clock; all state changes on rising edge
//  RESET_IN      in   1  synchronous, active-high reset
//  AS_IN         in   1  address strobe (active-high, already inverted)
//  UDS_IN        in   1  upper data strobe (active-high)
//  LDS_IN        in   1  lower data strobe (active-high)
//  WR_IN         in   1  1 = write cycle
//  REGION_IN     in   2  0 unmapped, 1 PROM, 2 SRAM, 3 I/O (from decoder)
//  STEPEN_IN     in   1  step mode enable (synchronised switch)
//  STEP_IN       in   1  step push-button (synchronised, debounced)
//  DTACK         out  1  data transfer acknowledge (active-high, registered)
//  BERR          out  1  bus error (active-high, registered; always 0 without BUS_TIMEOUT_EN)
//  CYCLE_ACTIVE  out  1  1 while the sequencer is not in IDLE (for LED/debug)
// BEHAVIOUR
//  - DTREQ = AS_IN & (UDS_IN | LDS_IN).
//  - Reset: state IDLE; DTACK=0, BERR=0, CYCLE_ACTIVE=0; counter=0.
//  - Reset mid-cycle wins over everything: the same edge returns to IDLE.
//  - States: IDLE, WAIT, STEP_HOLD, ACK, RELEASE, FAULT.
//  - IDLE: on DTREQ=1 at edge k, latch REGION_IN and load counter with the region wait W.
//    REGION_IN is sampled only at this edge; later changes are ignored.
//    * Mapped region, not step mode: W=0 -> ACK at edge k; else WAIT. DTACK rises at edge k+W.
//    * Mapped region, step mode: the cycle ends its wait in STEP_HOLD instead of ACK.
//    * Unmapped region: see CONFIGURATION.
//  - WAIT: decrement each edge. On the edge the counter hits 0, go to ACK (or STEP_HOLD if STEPEN_IN).
//  - STEP_HOLD: DTACK=0. On STEP_IN=1 go to ACK, asserting DTACK the same edge.
//    STEPEN_IN deasserted while holding: go to ACK on the next edge.
//  - ACK: DTACK=1. When DTREQ=0: DTACK<=0, then RELEASE if STEPEN_IN, else IDLE.
//  - RELEASE: DTACK=0. Leave for IDLE only when STEP_IN=0 (one bus cycle per press).
//    A new DTREQ while in RELEASE is held off until the return to IDLE.
//  - Aborted cycle: DTREQ=0 in WAIT/STEP_HOLD -> IDLE next edge; DTACK never asserted.
//  - FAULT: BERR=1, DTACK=0. When DTREQ=0 (and AS_IN=0): BERR<=0, go to IDLE.
//  - DTACK and BERR are never 1 simultaneously.
//  - CYCLE_ACTIVE = (state != IDLE), registered.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//    - Unmapped access: go to WAIT with counter=TIMEOUT-1; at 0 go to FAULT.
//    - Step mode does not suppress this.
//    - BERR rises at edge k+TIMEOUT.
//  BUS_TIMEOUT_EN undefined:
//    - Unmapped access is treated as a mapped region with W=0 (dummy ACK).
//    - BERR is tied 0; the FAULT state is not generated.
// STRUCTURE
//  - Package bus_seq_pkg holds:
//    * region codes REGION_NONE/PROM/SRAM/IO (2-bit)
//    * state encoding (3-bit localparams)
//    * region-to-wait lookup function
//  - One sub-module, bus_wait_counter: CNT_W-bit load/decrement counter.
//    * Sync clear, load, enable inputs; zero flag output.
//    * Used for both wait states and timeout.
//  - Top level is the FSM plus registered outputs only.
// TESTING
//  1. SRAM read: REGION=2, DTREQ at edge 0 -> DTACK=1 after edge 0; DTREQ drop at edge 3 -> DTACK=0 after edge 3.
//  2. PROM read: REGION=1, PROM_WAIT=2 -> DTACK low after edges 0-1, high after edge 2; then deasserts with DTREQ.
//  3. Step mode: STEPEN=1, SRAM -> holds DTACK=0 indefinitely.
//     STEP pulse -> exactly one DTACK.
//     STEP held through the next DTREQ -> no second DTACK until STEP released and pressed again.
//  4. Abort: PROM cycle, DTREQ dropped after edge 1 -> DTACK never asserts; IDLE after edge 2.
//  5. Timeout (BUS_TIMEOUT_EN, TIMEOUT=64): REGION=0 -> BERR=1 after edge 64, DTACK=0 throughout.
//     Without the macro: DTACK=1 after edge 0, BERR stuck 0.
//  6. Reset mid-WAIT (PROM, after edge 1) -> after the reset edge, DTACK=0, BERR=0, CYCLE_ACTIVE=0.
//     A fresh DTREQ then behaves as in test 2.

Source files
------------

// File: rtl/bus_cycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bus_seq_pkg
// Shared definitions for the 68000 DTACK/BERR bus-cycle sequencer:
//   - region codes delivered by the address decoder
//   - FSM state encoding (3-bit)
//   - region-to-wait-state lookup
// -----------------------------------------------------------------------------
package bus_seq_pkg;

  // Region codes as produced by the address decoder.
  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_PROM = 2'd1,
    REGION_SRAM = 2'd2,
    REGION_IO   = 2'd3
  } region_e;

  // State encoding, kept as explicit localparams so the codes are stable for
  // debug probes; the enum below reuses them.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT      = 3'd1;
  localparam logic [2:0] ST_STEP_HOLD = 3'd2;
  localparam logic [2:0] ST_ACK       = 3'd3;
  localparam logic [2:0] ST_RELEASE   = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT      = ST_WAIT,
    S_STEP_HOLD = ST_STEP_HOLD,
    S_ACK       = ST_ACK,
    S_RELEASE   = ST_RELEASE,
    S_FAULT     = ST_FAULT
  } state_e;

  // Wait cycles for a mapped region. Unmapped returns 0, which is exactly the
  // dummy-acknowledge behaviour when the bus timeout is not built in.
  function automatic int unsigned region_wait(region_e     region,
                                              int unsigned prom_w,
                                              int unsigned sram_w,
                                              int unsigned io_w);
    int unsigned w;
    w = 0;
    case (region)
      REGION_PROM: w = prom_w;
      REGION_SRAM: w = sram_w;
      REGION_IO:   w = io_w;
      default:     w = 0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// bus_cycle_sequencer_if
// Bus-side signals of the DTACK/BERR sequencer.
//   slave  : the sequencer (consumes strobes/region/step, drives DTACK/BERR)
//   master : the CPU/decoder side (drives strobes/region/step, observes acks)
// Signals:
//   AS_IN, UDS_IN, LDS_IN, WR_IN  bus strobes (active-high)
//   REGION_IN[1:0]                decoded region (see bus_seq_pkg::region_e)
//   STEPEN_IN, STEP_IN            single-step switch and push-button
//   DTACK, BERR, CYCLE_ACTIVE     registered sequencer outputs
// -----------------------------------------------------------------------------
interface bus_cycle_sequencer_if;
  logic       AS_IN;
  logic       UDS_IN;
  logic       LDS_IN;
  logic       WR_IN;
  logic [1:0] REGION_IN;
  logic       STEPEN_IN;
  logic       STEP_IN;
  logic       DTACK;
  logic       BERR;
  logic       CYCLE_ACTIVE;

  modport slave (
    input  AS_IN, UDS_IN, LDS_IN, WR_IN, REGION_IN, STEPEN_IN, STEP_IN,
    output DTACK, BERR, CYCLE_ACTIVE
  );

  modport master (
    output AS_IN, UDS_IN, LDS_IN, WR_IN, REGION_IN, STEPEN_IN, STEP_IN,
    input  DTACK, BERR, CYCLE_ACTIVE
  );
endinterface

// File: rtl/bus_cycle_sequencer_wait_counter.sv
// -----------------------------------------------------------------------------
// bus_wait_counter
// CNT_W-bit load/decrement counter shared by wait-state and timeout counting.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        synchronous clear to 0
//   load       load load_val (priority below clr)
//   en         decrement by one (stops at 0)
//   zero       count == 0
// -----------------------------------------------------------------------------
module bus_wait_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// bus_cycle_sequencer
// Clocked DTACK/BERR sequencer for a 68000 bus. Inserts per-region wait
// states, supports single-step pausing of bus cycles and, optionally, a
// bus-error timeout for unmapped accesses.
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : unmapped access waits TIMEOUT cycles, then asserts BERR
//   undefined : unmapped access gets a dummy zero-wait DTACK; BERR tied 0
// Ports:
//   CPUCLK_IN  CPU clock, all state changes on its rising edge
//   RESET_IN   synchronous active-high reset
//   bus        bus_cycle_sequencer_if.slave (strobes, region, step, acks)
// Parameters:
//   PROM_WAIT, SRAM_WAIT, IO_WAIT  wait cycles per region
//   TIMEOUT                        unmapped-access timeout (BUS_TIMEOUT_EN)
//   CNT_W                          counter width, holds max(waits, TIMEOUT)
// -----------------------------------------------------------------------------
module bus_cycle_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned PROM_WAIT = 2,
  parameter int unsigned SRAM_WAIT = 0,
  parameter int unsigned IO_WAIT   = 1,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                   CPUCLK_IN,
  input  logic                   RESET_IN,
  bus_cycle_sequencer_if.slave   bus
);

  state_e           state_q, state_d;
  logic             dtack_q, dtack_d;
  logic             active_q, active_d;
  logic             dtreq;
  region_e          region_in;
  int unsigned      wait_w;
  logic             cnt_clr, cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

`ifdef BUS_TIMEOUT_EN
  region_e          region_q, region_d;
  logic             berr_q, berr_d;
`endif

  assign dtreq     = bus.AS_IN & (bus.UDS_IN | bus.LDS_IN);
  assign region_in = region_e'(bus.REGION_IN);
  assign wait_w    = region_wait(region_in, PROM_WAIT, SRAM_WAIT, IO_WAIT);

  // The counter is loaded with (wait - 1) and WAIT exits when it reads zero,
  // so a wait of W cycles puts DTACK up W edges after the request edge.
  bus_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk      (CPUCLK_IN),
    .rst      (RESET_IN),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    region_d = region_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (dtreq) begin
`ifdef BUS_TIMEOUT_EN
          region_d = region_in;
          if (region_in == REGION_NONE) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(TIMEOUT - 1);
            state_d  = S_WAIT;
          end else
`endif
          if (wait_w == 0) begin
            state_d = bus.STEPEN_IN ? S_STEP_HOLD : S_ACK;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(wait_w - 1);
            state_d  = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!dtreq) begin
          state_d = S_IDLE;
        end else if (cnt_zero) begin
`ifdef BUS_TIMEOUT_EN
          // Step mode must not hide a bus error, so FAULT is checked first.
          if (region_q == REGION_NONE) state_d = S_FAULT;
          else
`endif
          state_d = bus.STEPEN_IN ? S_STEP_HOLD : S_ACK;
        end else begin
          cnt_en = 1'b1;
        end
      end

      S_STEP_HOLD: begin
        if (!dtreq) begin
          state_d = S_IDLE;
        end else if (bus.STEP_IN || !bus.STEPEN_IN) begin
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        if (!dtreq) begin
          state_d = bus.STEPEN_IN ? S_RELEASE : S_IDLE;
        end
      end

      // Holding here until the button is released gives one cycle per press.
      S_RELEASE: begin
        if (!bus.STEP_IN) begin
          state_d = S_IDLE;
        end
      end

`ifdef BUS_TIMEOUT_EN
      S_FAULT: begin
        if (!bus.AS_IN) begin
          state_d = S_IDLE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Keep the counter at zero whenever the FSM is (or returns to) idle.
  assign cnt_clr = (state_d == S_IDLE);

  // Outputs are decoded from the next state and registered, so DTACK/BERR
  // change on the same edge as the state that defines them.
  assign dtack_d  = (state_d == S_ACK);
  assign active_d = (state_d != S_IDLE);
`ifdef BUS_TIMEOUT_EN
  assign berr_d   = (state_d == S_FAULT);
`endif

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state_q  <= S_IDLE;
      dtack_q  <= 1'b0;
      active_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      region_q <= REGION_NONE;
      berr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dtack_q  <= dtack_d;
      active_q <= active_d;
`ifdef BUS_TIMEOUT_EN
      region_q <= region_d;
      berr_q   <= berr_d;
`endif
    end
  end

  assign bus.DTACK        = dtack_q;
  assign bus.CYCLE_ACTIVE = active_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.BERR         = berr_q;
`else
  assign bus.BERR         = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_cycle_sequencer
// Directed bench for bus_cycle_sequencer (PROM_WAIT=2, SRAM_WAIT=0, IO_WAIT=1,
// TIMEOUT=64). A vector table covers reset, normal cycles, abort and reset
// mid-cycle; hand-written sequences cover step mode and the unmapped access.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_bus_cycle_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  bus_cycle_sequencer_if bus ();

  bus_cycle_sequencer #(
    .PROM_WAIT (2),
    .SRAM_WAIT (0),
    .IO_WAIT   (1),
    .TIMEOUT   (64),
    .CNT_W     (8)
  ) dut (
    .CPUCLK_IN (clk),
    .RESET_IN  (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {DTACK, BERR, CYCLE_ACTIVE}.
  typedef struct {
    string      name;
    logic       rst;
    logic       as_s;
    logic       uds;
    logic       lds;
    logic [1:0] region;
    logic       stepen;
    logic       step;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {bus.DTACK, bus.BERR, bus.CYCLE_ACTIVE};
    n_checks++;
    if (got !== exp || (bus.DTACK && bus.BERR)) begin
      n_errors++;
      $display("FAIL %s: got {dtack,berr,active}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic as_s, input logic uds, input logic lds,
                       input logic [1:0] region, input logic stepen,
                       input logic step);
    bus.AS_IN     = as_s;
    bus.UDS_IN    = uds;
    bus.LDS_IN    = lds;
    bus.WR_IN     = 1'b0;
    bus.REGION_IN = region;
    bus.STEPEN_IN = stepen;
    bus.STEP_IN   = step;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic r, input logic as_s,
                     input logic uds, input logic lds, input logic [1:0] region,
                     input logic stepen, input logic step, input logic [2:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.as_s = as_s; v.uds = uds; v.lds = lds;
    v.region = region; v.stepen = stepen; v.step = step; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    //   name            rst as uds lds reg  sten step  {dt,be,act}
    add("reset",         1, 0, 0, 0, 2'd0, 0, 0, 3'b000);
    add("as_no_strobe",  0, 1, 0, 0, 2'd2, 0, 0, 3'b000);
    add("sram_e0",       0, 1, 1, 0, 2'd2, 0, 0, 3'b101);
    add("sram_e1",       0, 1, 1, 0, 2'd2, 0, 0, 3'b101);
    add("sram_e2",       0, 1, 1, 0, 2'd2, 0, 0, 3'b101);
    add("sram_drop_e3",  0, 0, 0, 0, 2'd2, 0, 0, 3'b000);
    add("prom_e0",       0, 1, 0, 1, 2'd1, 0, 0, 3'b001);
    add("prom_e1",       0, 1, 0, 1, 2'd1, 0, 0, 3'b001);
    add("prom_e2_regchg",0, 1, 0, 1, 2'd2, 0, 0, 3'b101);
    add("prom_e3",       0, 1, 0, 1, 2'd0, 0, 0, 3'b101);
    add("prom_drop",     0, 0, 0, 0, 2'd1, 0, 0, 3'b000);
    add("io_e0",         0, 1, 1, 1, 2'd3, 0, 0, 3'b001);
    add("io_e1",         0, 1, 1, 1, 2'd3, 0, 0, 3'b101);
    add("io_drop",       0, 0, 1, 1, 2'd3, 0, 0, 3'b000);
    add("abort_e0",      0, 1, 1, 0, 2'd1, 0, 0, 3'b001);
    add("abort_e1",      0, 1, 1, 0, 2'd1, 0, 0, 3'b001);
    add("abort_e2",      0, 1, 0, 0, 2'd1, 0, 0, 3'b000);
    add("abort_idle",    0, 0, 0, 0, 2'd1, 0, 0, 3'b000);
    add("rstw_e0",       0, 1, 1, 1, 2'd1, 0, 0, 3'b001);
    add("rstw_e1",       0, 1, 1, 1, 2'd1, 0, 0, 3'b001);
    add("rstw_reset",    1, 1, 1, 1, 2'd1, 0, 0, 3'b000);
    add("rstw_new_e0",   0, 1, 1, 1, 2'd1, 0, 0, 3'b001);
    add("rstw_new_e1",   0, 1, 1, 1, 2'd1, 0, 0, 3'b001);
    add("rstw_new_e2",   0, 1, 1, 1, 2'd1, 0, 0, 3'b101);
    add("rstw_new_drop", 0, 0, 0, 0, 2'd1, 0, 0, 3'b000);
    add("rsta_e0",       0, 1, 1, 0, 2'd2, 0, 0, 3'b101);
    add("rsta_reset",    1, 1, 1, 0, 2'd2, 0, 0, 3'b000);
    add("rsta_again",    0, 1, 1, 0, 2'd2, 0, 0, 3'b101);
    add("rsta_drop",     0, 0, 0, 0, 2'd2, 0, 0, 3'b000);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      drive(vecs[i].as_s, vecs[i].uds, vecs[i].lds, vecs[i].region,
            vecs[i].stepen, vecs[i].step);
      tick();
      check(vecs[i].name, vecs[i].exp);
    end
    rst = 1'b0;

    // Step mode, SRAM: hold without DTACK until the button is pressed.
    drive(1, 1, 0, 2'd2, 1, 0); tick(); check("step_hold_enter", 3'b001);
    for (int i = 0; i < 5; i++) begin
      tick(); check($sformatf("step_hold_%0d", i), 3'b001);
    end
    drive(1, 1, 0, 2'd2, 1, 1); tick(); check("step_press_ack", 3'b101);
    tick();                            check("step_ack_held", 3'b101);
    // DTREQ drops while the button is still down: RELEASE, no DTACK.
    drive(0, 0, 0, 2'd2, 1, 1); tick(); check("step_release", 3'b001);
    // A new request while the button stays down must not be acknowledged.
    drive(1, 1, 0, 2'd2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); check($sformatf("step_blocked_%0d", i), 3'b001);
    end
    drive(1, 1, 0, 2'd2, 1, 0); tick(); check("step_btn_up_idle", 3'b000);
    tick();                            check("step_second_hold", 3'b001);
    tick();                            check("step_second_wait", 3'b001);
    drive(1, 1, 0, 2'd2, 1, 1); tick(); check("step_second_ack", 3'b101);
    drive(1, 1, 0, 2'd2, 1, 0); tick(); check("step_ack_btn_up", 3'b101);
    drive(0, 0, 0, 2'd2, 1, 0); tick(); check("step_rel_pass", 3'b001);
    tick();                            check("step_back_idle", 3'b000);

    // Step mode with a PROM wait: the wait ends in STEP_HOLD, then STEPEN
    // is switched off and the cycle completes on the next edge.
    drive(1, 0, 1, 2'd1, 1, 0); tick(); check("stwait_e0", 3'b001);
    tick();                            check("stwait_e1", 3'b001);
    tick();                            check("stwait_e2_hold", 3'b001);
    drive(1, 0, 1, 2'd1, 0, 0); tick(); check("stepen_off_ack", 3'b101);
    drive(0, 0, 0, 2'd1, 0, 0); tick(); check("stepen_off_idle", 3'b000);

    // Unmapped access.
    drive(1, 1, 1, 2'd0, 0, 0);
`ifdef BUS_TIMEOUT_EN
    begin
      int bad;
      bad = 0;
      for (int e = 0; e < 64; e++) begin
        tick();
        if ({bus.DTACK, bus.BERR, bus.CYCLE_ACTIVE} !== 3'b001) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_errors++;
        $display("FAIL timeout_pre: %0d of edges 0..63 not {dtack,berr,active}=001", bad);
      end
    end
    tick();                            check("timeout_berr_e64", 3'b011);
    drive(1, 0, 0, 2'd0, 0, 0); tick(); check("fault_as_held", 3'b011);
    drive(0, 0, 0, 2'd0, 0, 0); tick(); check("fault_clear", 3'b000);
`else
    tick();                            check("unmapped_dummy_ack", 3'b101);
    for (int i = 0; i < 3; i++) begin
      tick(); check($sformatf("unmapped_no_berr_%0d", i), 3'b101);
    end
    drive(0, 0, 0, 2'd0, 0, 0); tick(); check("unmapped_drop", 3'b000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
